temporizador_regressivo: RTL and testbench

Loadable down-counter with a control FSM: the counterpart of the modulo-M up-counter used across the lab designs. It is loaded with an initial count and decrements toward zero on qualified tick cycles (`conta`, typically driven by an up-counter's `fim`). It supports pause and cancel, flags the half-way point, and signals expiry with a one-cycle `fim` pulse plus a level `esgotado`. It sits in the datapath of game/timeout controllers, where the FSM loads a time limit and waits for expiry.

---
 rtl/temporizador_pkg.sv | 14 +
 rtl/temporizador_regressivo.sv | 125 ++++++++++++
 tb/tb_temporizador_regressivo.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/temporizador_pkg.sv
// temporizador_pkg
// Shared definitions for the loadable down-counter (temporizador_regressivo).
// Holds the FSM state encoding, which is also the value shown on the
// 'estado' debug/display output, so the encoding is fixed and not arbitrary.
package temporizador_pkg;

    typedef enum logic [1:0] {
        OCIOSO   = 2'b00,  // idle, Q = 0
        CONTANDO = 2'b01,  // counting down on conta ticks
        PAUSADO  = 2'b10,  // counting held
        ESGOTADO = 2'b11   // expired, Q = 0 until carrega or cancela
    } estado_t;

endpackage : temporizador_pkg

// File: rtl/temporizador_regressivo.sv
// temporizador_regressivo
// Loadable down-counter with a control FSM. It is loaded with a start count,
// decrements once per cycle with conta=1 while counting, and signals expiry
// with a one-cycle fim pulse plus the esgotado level. Supports pause, cancel
// and a half-way flag.
//
// There is no valid/ready handshake: every input is a level sampled on each
// rising clock edge, and all inputs are evaluated by a fixed priority
// reset > carrega > cancela > pausa > conta.
//
// Ports
//   clock     in   1  single clock, rising edge
//   reset     in   1  synchronous, active-high
//   carrega   in   1  load valor and start counting
//   valor     in   N  start count, sampled only with carrega
//   conta     in   1  tick qualifier, one decrement per tick
//   pausa     in   1  level, holds the count while high
//   cancela   in   1  abort to idle with Q = 0, no fim
//   Q         out  N  current count (registered)
//   fim       out  1  registered one-cycle pulse on expiry
//   esgotado  out  1  high in ESGOTADO
//   meio      out  1  Q at the half-way point of the loaded count
//   ocupado   out  1  high in CONTANDO or PAUSADO
//   estado    out  2  FSM state, for debug/display
module temporizador_regressivo
    import temporizador_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         carrega,
    input  logic [N-1:0] valor,
    input  logic         conta,
    input  logic         pausa,
    input  logic         cancela,
    output logic [N-1:0] Q,
    output logic         fim,
    output logic         esgotado,
    output logic         meio,
    output logic         ocupado,
    output logic [1:0]   estado
);

    localparam logic [N-1:0] UM = N'(1);

    estado_t      state_q, state_d;
    logic [N-1:0] q_q, q_d;
    logic [N-1:0] base_q, base_d;
    logic         fim_q, fim_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= OCIOSO;
            q_q     <= '0;
            base_q  <= '0;
            fim_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            base_q  <= base_d;
            fim_q   <= fim_d;
        end
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        base_d  = base_q;
        fim_d   = 1'b0;  // fim only ever lasts the one cycle after expiry

        if (carrega) begin
            q_d    = valor;
            base_d = valor;
            if (valor != '0) begin
                state_d = CONTANDO;
            end else begin
                // A zero load expires immediately.
                state_d = ESGOTADO;
                fim_d   = 1'b1;
            end
        end else if (cancela) begin
            q_d     = '0;
            state_d = OCIOSO;
        end else begin
            unique case (state_q)
                CONTANDO: begin
                    if (pausa) begin
                        state_d = PAUSADO;
                    end else if (conta) begin
                        if (q_q > UM) begin
                            q_d = q_q - UM;
                        end else begin
                            // Final tick; the <= also keeps Q from wrapping.
                            q_d     = '0;
                            state_d = ESGOTADO;
                            fim_d   = 1'b1;
                        end
                    end
                end
                PAUSADO: begin
                    // The release cycle itself does not decrement.
                    if (!pausa) begin
                        state_d = CONTANDO;
                    end
                end
                ESGOTADO: begin
                    q_d = '0;
                end
                default: begin
                    q_d = '0;
                end
            endcase
        end
    end

    assign Q        = q_q;
    assign fim      = fim_q;
    assign estado   = state_q;
    assign esgotado = (state_q == ESGOTADO);
    assign ocupado  = (state_q == CONTANDO) || (state_q == PAUSADO);
    // base >= 2 is any bit set above bit 0.
    assign meio     = ocupado && (|base_q[N-1:1]) && (q_q == (base_q >> 1));

endmodule : temporizador_regressivo

// File: tb/tb_temporizador_regressivo.sv
module tb_temporizador_regressivo;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] q;
    logic [1:0]   st;
    logic         fim;
    logic         meio;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         carrega = 1'b0;
  logic [W-1:0] valor = '0;
  logic         conta = 1'b0;
  logic         pausa = 1'b0;
  logic         cancela = 1'b0;
  logic [W-1:0] q;
  logic         fim, esgotado, meio, ocupado;
  logic [1:0]   estado;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  temporizador_regressivo #(.N(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .carrega  (carrega),
    .valor    (valor),
    .conta    (conta),
    .pausa    (pausa),
    .cancela  (cancela),
    .Q        (q),
    .fim      (fim),
    .esgotado (esgotado),
    .meio     (meio),
    .ocupado  (ocupado),
    .estado   (estado)
  );

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver + scoreboard ----------------
  // Drives one cycle of inputs, queues what the outputs must be after the
  // next rising edge, then pops and compares once the edge has passed.
  task automatic step(input logic r, input logic c, input logic [W-1:0] v,
                      input logic ct, input logic p, input logic cn,
                      input logic [W-1:0] eq, input logic [1:0] es,
                      input logic ef, input logic em);
    exp_t e;
    reset = r; carrega = c; valor = v; conta = ct; pausa = p; cancela = cn;
    exp_q.push_back('{q: eq, st: es, fim: ef, meio: em});
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    check_eq("Q", 32'(q), 32'(e.q));
    check_eq("estado", 32'(estado), 32'(e.st));
    check_eq("fim", 32'(fim), 32'(e.fim));
    check_eq("meio", 32'(meio), 32'(e.meio));
    check_eq("esgotado", 32'(esgotado), 32'(e.st == 2'b11));
    check_eq("ocupado", 32'(ocupado), 32'(e.st == 2'b01 || e.st == 2'b10));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int v;
    #2;

    // Reset, then idle with conta=1.
    step(1, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0);

    // Load 4, count down with conta held.
    step(0, 1, 4, 1, 0, 0, 4, 2'b01, 0, 0);
    step(0, 0, 0, 1, 0, 0, 3, 2'b01, 0, 0);
    step(0, 0, 0, 1, 0, 0, 2, 2'b01, 0, 1);
    step(0, 0, 0, 1, 0, 0, 1, 2'b01, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 2'b11, 1, 0);
    step(0, 0, 0, 1, 0, 0, 0, 2'b11, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 2'b11, 0, 0);

    // Load 6, pause at Q=4 (two pausa cycles plus the release cycle hold Q).
    step(0, 1, 6, 1, 0, 0, 6, 2'b01, 0, 0);
    step(0, 0, 0, 1, 0, 0, 5, 2'b01, 0, 0);
    step(0, 0, 0, 1, 0, 0, 4, 2'b01, 0, 0);
    step(0, 0, 0, 1, 1, 0, 4, 2'b10, 0, 0);
    step(0, 0, 0, 1, 1, 0, 4, 2'b10, 0, 0);
    step(0, 0, 0, 1, 0, 0, 4, 2'b01, 0, 0);
    step(0, 0, 0, 1, 0, 0, 3, 2'b01, 0, 1);
    step(0, 0, 0, 1, 0, 0, 2, 2'b01, 0, 0);
    step(0, 0, 0, 1, 0, 0, 1, 2'b01, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 2'b11, 1, 0);

    // Zero load: straight to ESGOTADO with a single fim.
    step(0, 1, 0, 1, 0, 0, 0, 2'b11, 1, 0);
    step(0, 0, 0, 1, 0, 0, 0, 2'b11, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 2'b11, 0, 0);

    // Load 3, cancel at Q=2.
    step(0, 1, 3, 1, 0, 0, 3, 2'b01, 0, 0);
    step(0, 0, 0, 1, 0, 0, 2, 2'b01, 0, 0);
    step(0, 0, 0, 1, 0, 1, 0, 2'b00, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0);

    // carrega coincident with the final tick: load wins, no fim.
    step(0, 1, 3, 1, 0, 0, 3, 2'b01, 0, 0);
    step(0, 0, 0, 1, 0, 0, 2, 2'b01, 0, 0);
    step(0, 0, 0, 1, 0, 0, 1, 2'b01, 0, 1);
    step(0, 1, 2, 1, 0, 0, 2, 2'b01, 0, 0);
    step(0, 0, 0, 1, 0, 0, 1, 2'b01, 0, 1);
    step(0, 0, 0, 1, 0, 0, 0, 2'b11, 1, 0);

    // cancela coincident with the final tick: cancel wins, no fim.
    step(0, 1, 2, 1, 0, 0, 2, 2'b01, 0, 0);
    step(0, 0, 0, 1, 0, 0, 1, 2'b01, 0, 1);
    step(0, 0, 0, 1, 0, 1, 0, 2'b00, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0);

    // reset mid-count at Q=5.
    step(0, 1, 7, 1, 0, 0, 7, 2'b01, 0, 0);
    step(0, 0, 0, 1, 0, 0, 6, 2'b01, 0, 0);
    step(0, 0, 0, 1, 0, 0, 5, 2'b01, 0, 0);
    step(1, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0);

    // Random loads counted to expiry, then cancelled out of ESGOTADO.
    for (int k = 0; k < 4; k++) begin
      v = $urandom_range(2, 40);
      step(0, 1, W'(v), 1, 0, 0, W'(v), 2'b01, 0, (v / 2) == v);
      for (int t = v - 1; t >= 1; t--)
        step(0, 0, 0, 1, 0, 0, W'(t), 2'b01, 0, t == (v / 2));
      step(0, 0, 0, 1, 0, 0, 0, 2'b11, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 2'b11, 0, 0);
      step(0, 0, 0, 0, 0, 1, 0, 2'b00, 0, 0);
    end

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_temporizador_regressivo
